// File: rtl/apb_slave_regfile.sv
// APB completer holding a DEPTH x 32-bit register file with programmable wait states.
// Optional error responses and a read-only ID word are enabled by APB_SLAVE_PSLVERR_EN.
module apb_slave_regfile #(
    parameter int unsigned SLAVE_IDX   = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [1:0]  SI   = SLAVE_IDX[1:0];
    localparam logic [3:0]  WS   = WAIT_STATES[3:0];
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [31:0] ID_WORD = {16'hA5B0, 8'h00, SLAVE_IDX[7:0]};

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e        state_q;
    logic [3:0]    wcnt_q;
    logic [AW-1:0] idx_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic          inr_q;
    logic [31:0]   prdata_q;
    logic [31:0]   mem_q [DEPTH];

    logic          sel;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          ready_raw;
    logic          err_raw;
    logic          wr_ok;
    logic          unused_addr;

    assign sel         = Pselx[SI];
    assign idx         = Paddr[AW+1:2];
    assign in_range    = (Paddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign unused_addr = ^Paddr[1:0];

    assign ready_raw = (state_q == ACCESS) && (wcnt_q == WS);

`ifdef APB_SLAVE_PSLVERR_EN
    // The top word is a read-only ID; writing it is an error.
    assign err_raw = ~inr_q | (write_q & (idx_q == LAST));
`else
    assign err_raw = 1'b0;
`endif

    assign wr_ok = ready_raw & sel & Penable & write_q & inr_q & ~err_raw;

    assign Pready  = ready_raw & ~Hreset;
    assign Pslverr = ready_raw & err_raw & ~Hreset;
    assign Prdata  = prdata_q;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            inr_q    <= 1'b0;
            prdata_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
`ifdef APB_SLAVE_PSLVERR_EN
            mem_q[LAST] <= ID_WORD;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel && !Penable) begin
                        idx_q   <= idx;
                        write_q <= Pwrite;
                        wdata_q <= Pwdata;
                        inr_q   <= in_range;
                        wcnt_q  <= '0;
                        state_q <= ACCESS;
                        if (!Pwrite) begin
                            prdata_q <= in_range ? mem_q[idx] : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!sel) begin
                        state_q <= IDLE;
                    end else if (Penable) begin
                        if (!ready_raw) begin
                            wcnt_q <= wcnt_q + 4'd1;
                        end else begin
                            if (wr_ok) begin
                                mem_q[idx_q] <= wdata_q;
                            end
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: three completers (wait states 0, 3, 2) share one APB bus.
module tb_apb_slave_regfile;

    logic        Hclk;
    logic        Hreset;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] prd [3];
    logic        rdy [3];
    logic        err [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          s;
        bit          rd;
        logic [31:0] data;
        bit          err;
        int          waits;
    } exp_t;

    exp_t q[$];

`ifdef APB_SLAVE_PSLVERR_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    apb_slave_regfile #(.SLAVE_IDX(0), .WAIT_STATES(0)) u0 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prd[0]), .Pready(rdy[0]), .Pslverr(err[0])
    );

    apb_slave_regfile #(.SLAVE_IDX(1), .WAIT_STATES(3)) u1 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prd[1]), .Pready(rdy[1]), .Pslverr(err[1])
    );

    apb_slave_regfile #(.SLAVE_IDX(2), .WAIT_STATES(2)) u2 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prd[2]), .Pready(rdy[2]), .Pslverr(err[2])
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation whenever the selected completer signals ready.
    int wt = 0;
    int ms;
    exp_t e;
    always @(negedge Hclk) begin
        if (!Penable) begin
            wt = 0;
        end else if (Pselx != 3'b000) begin
            ms = Pselx[2] ? 2 : (Pselx[1] ? 1 : 0);
            for (int j = 0; j < 3; j++) begin
                if (j != ms) chk($sformatf("idle_rdy%0d", j), 32'(rdy[j]), 32'd0);
            end
            if (!rdy[ms]) begin
                wt++;
            end else if (q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("slave", ms, e.s);
                chk("waits", wt, e.waits);
                chk("pslverr", 32'(err[ms]), 32'(e.err));
                if (e.rd) chk("prdata", prd[ms], e.data);
                wt = 0;
            end
        end
    end

    task automatic xfer(input int s, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er,
                        input bit ee, input int ew);
        int n;
        q.push_back('{s, !w, er, ee, ew});
        Pselx   = 3'(1 << s);
        Penable = 1'b0;
        Pwrite  = w;
        Paddr   = a;
        Pwdata  = d;
        @(posedge Hclk);
        #1;
        Penable = 1'b1;
        Paddr   = ~a;
        Pwdata  = ~d;
        Pwrite  = !w;
        n = 0;
        forever begin
            @(negedge Hclk);
            if (rdy[s]) break;
            n++;
            if (n > 30) begin
                chk("timeout", 32'(n), 32'(ew));
                break;
            end
        end
        @(posedge Hclk);
        #1;
        Pselx   = 3'b000;
        Penable = 1'b0;
    endtask

    initial begin
        Hreset  = 1'b1;
        Pselx   = 3'b000;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = '0;
        Pwdata  = '0;
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_rdy%0d", i), 32'(rdy[i]), 32'd0);
            chk($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
            chk($sformatf("rst_prd%0d", i), prd[i], 32'd0);
        end
        @(posedge Hclk);
        #1;
        Hreset = 1'b0;

        xfer(0, 1, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0, 0, 0);
        xfer(0, 0, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 0, 0);

        xfer(1, 1, 32'h8000_0004, 32'h1234_5678, 32'h0, 0, 3);
        xfer(1, 0, 32'h8000_0004, 32'h0, 32'h1234_5678, 0, 3);

        xfer(0, 0, 32'h9000_0000, 32'h0, 32'h0, FEAT, 0);
        xfer(0, 1, 32'h9000_0008, 32'h5555_5555, 32'h0, FEAT, 0);
        xfer(0, 0, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 0, 0);

        xfer(1, 1, 32'h8000_0008, 32'hAAAA_AAAA, 32'h0, 0, 3);
        xfer(0, 0, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 0, 0);
        xfer(1, 0, 32'h8000_0008, 32'h0, 32'hAAAA_AAAA, 0, 3);

        if (FEAT) begin
            xfer(0, 1, 32'h8000_003C, 32'hFFFF_FFFF, 32'h0, 1, 0);
            xfer(0, 0, 32'h8000_003C, 32'h0, 32'hA5B0_0000, 0, 0);
            xfer(1, 0, 32'h8000_003C, 32'h0, 32'hA5B0_0001, 0, 3);
        end else begin
            xfer(0, 1, 32'h8000_003C, 32'h0BAD_F00D, 32'h0, 0, 0);
            xfer(0, 0, 32'h8000_003C, 32'h0, 32'h0BAD_F00D, 0, 0);
        end

        Pselx   = 3'b100;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = 32'h8000_000C;
        Pwdata  = 32'h7777_7777;
        @(posedge Hclk);
        #1;
        Penable = 1'b1;
        @(posedge Hclk);
        #1;
        Pselx   = 3'b000;
        Penable = 1'b0;
        @(posedge Hclk);
        @(negedge Hclk);
        chk("abort_rdy", 32'(rdy[2]), 32'd0);
        #1;
        xfer(2, 0, 32'h8000_000C, 32'h0, 32'h0, 0, 2);

        Pselx   = 3'b001;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = 32'h8000_0010;
        Pwdata  = 32'hCAFE_F00D;
        @(posedge Hclk);
        #1;
        Penable = 1'b1;
        Hreset  = 1'b1;
        @(negedge Hclk);
        chk("rst_mid_rdy", 32'(rdy[0]), 32'd0);
        chk("rst_mid_err", 32'(err[0]), 32'd0);
        @(posedge Hclk);
        #1;
        Hreset  = 1'b0;
        Pselx   = 3'b000;
        Penable = 1'b0;
        @(negedge Hclk);
        chk("rst_mid_prd", prd[0], 32'd0);
        #1;
        xfer(0, 0, 32'h8000_0010, 32'h0, 32'h0, 0, 0);
        xfer(0, 0, 32'h8000_0008, 32'h0, 32'h0, 0, 0);
        xfer(0, 0, 32'h8000_003C, 32'h0, FEAT ? 32'hA5B0_0000 : 32'h0, 0, 0);
        xfer(1, 0, 32'h8000_0004, 32'h0, 32'h0, 0, 3);

        repeat (2) @(posedge Hclk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
